data_mem_subsys: RTL and testbench

- Data-side memory subsystem directly downstream of the RV32I core's load/store port.
- Consumes funct3, address, write data and write enable from the core, and returns load data the same cycle.
- Contains a word-organised data RAM with byte/half/word stores and sign/zero-extended loads, plus a memory-mapped cycle timer with a compare interrupt.
- The combinational read path matches the single-cycle core; all state updates on the clock edge.

---
 rtl/data_mem_subsys.sv | 78 +++++++
 tb/tb_data_mem_subsys.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/data_mem_subsys.sv
// data_mem_subsys: word RAM with byte/half/word access plus memory-mapped compare timer
module data_mem_subsys #(
  parameter int          RAM_DEPTH = 256,
  parameter logic [31:0] TMR_BASE  = 32'h1000_0000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [2:0]  iFunct3,
  input  logic        iData_WrEn,
  input  logic [31:0] iData_Addr,
  input  logic [31:0] iData_WrData,
  output logic [31:0] oData_RdData,
  output logic        oMisalign,
  output logic        oTimer_Irq
);
  localparam int AW = $clog2(RAM_DEPTH);
  logic [31:0]   mem [RAM_DEPTH];
  logic [31:0]   cnt, cmp;
  logic          en, pend;
  logic          ram_hit, tmr_hit, wr_ok, ram_we, tmr_we;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [4:0]    sel;
  logic [31:0]   word, ram_rd, tmr_rd, wd;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be;
  assign ram_hit = iData_Addr < 32'(RAM_DEPTH * 4);
  assign tmr_hit = iData_Addr[31:4] == TMR_BASE[31:4];
  assign idx     = iData_Addr[AW+1:2];
  assign off     = iData_Addr[3:2];
  assign sel     = {iData_Addr[1:0], 3'b000};
  assign oMisalign = (iFunct3[1:0] == 2'b01 && iData_Addr[0]) ||
                     (iFunct3[1:0] == 2'b10 && iData_Addr[1:0] != 2'b00);
  // Reset outranks any store issued in the same cycle.
  assign wr_ok   = iData_WrEn && !oMisalign && !iRst;
  assign ram_we  = wr_ok && ram_hit;
  assign tmr_we  = wr_ok && tmr_hit && iFunct3 == 3'b010;
  assign oTimer_Irq = pend;
  // Load path: extract lane, extend, and mux between RAM, timer and unmapped space.
  always_comb begin
    word   = mem[idx];
    byte_v = word[sel +: 8];
    half_v = iData_Addr[1] ? word[31:16] : word[15:0];
    ram_rd = iFunct3 == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
             iFunct3 == 3'b001 ? {{16{half_v[15]}}, half_v} :
             iFunct3 == 3'b100 ? {24'b0, byte_v} :
             iFunct3 == 3'b101 ? {16'b0, half_v} : word;
    tmr_rd = off == 2'd0 ? cnt :
             off == 2'd1 ? cmp :
             off == 2'd2 ? {30'b0, pend, en} : 32'b0;
    oData_RdData = oMisalign ? 32'b0 : ram_hit ? ram_rd : tmr_hit ? tmr_rd : 32'b0;
    wd = iFunct3[1:0] == 2'b00 ? {4{iData_WrData[7:0]}} :
         iFunct3[1:0] == 2'b01 ? {2{iData_WrData[15:0]}} : iData_WrData;
    be = iFunct3[1:0] == 2'b00 ? 4'b0001 << iData_Addr[1:0] :
         iFunct3[1:0] == 2'b01 ? (iData_Addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  // RAM byte-lane stores; contents survive reset.
  always_ff @(posedge iClk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
  // Timer: software writes beat the increment, a compare hit beats the W1C.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt  <= '0;
      cmp  <= '0;
      en   <= 1'b0;
      pend <= 1'b0;
    end else begin
      cnt  <= (tmr_we && off == 2'd0) ? iData_WrData : en ? cnt + 32'd1 : cnt;
      cmp  <= (tmr_we && off == 2'd1) ? iData_WrData : cmp;
      en   <= (tmr_we && off == 2'd2) ? iData_WrData[0] : en;
      pend <= (en && cnt == cmp) ? 1'b1 :
              (tmr_we && off == 2'd2 && iData_WrData[1]) ? 1'b0 : pend;
    end
  end
endmodule

// File: tb/tb_data_mem_subsys.sv
// tb_data_mem_subsys: directed checks of RAM lanes, alignment, timer and decode
module tb_data_mem_subsys;
  localparam logic [31:0] TB = 32'h1000_0000;
  logic        iClk, iRst, iData_WrEn, oMisalign, oTimer_Irq;
  logic [2:0]  iFunct3;
  logic [31:0] iData_Addr, iData_WrData, oData_RdData;
  int checks = 0;
  int errors = 0;

  data_mem_subsys dut (
    .iClk(iClk), .iRst(iRst), .iFunct3(iFunct3), .iData_WrEn(iData_WrEn),
    .iData_Addr(iData_Addr), .iData_WrData(iData_WrData),
    .oData_RdData(oData_RdData), .oMisalign(oMisalign), .oTimer_Irq(oTimer_Irq)
  );

  initial begin
    iClk = 0;
    forever #5 iClk = ~iClk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    iFunct3 = f3;
    iData_Addr = a;
    iData_WrData = d;
    iData_WrEn = 1;
    tick();
    iData_WrEn = 0;
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    iFunct3 = f3;
    iData_Addr = a;
    iData_WrEn = 0;
    #1;
    check(tag, oData_RdData, exp);
  endtask

  initial begin
    iRst = 1;
    iData_WrEn = 0;
    iFunct3 = 3'b010;
    iData_Addr = 0;
    iData_WrData = 0;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 0;
    check("rst_irq", {31'b0, oTimer_Irq}, 32'h0);
    ld("rst_ctrl", 3'b010, TB + 8, 32'h0);
    ld("rst_cnt", 3'b010, TB, 32'h0);

    st(3'b010, TB + 4, 32'd5);
    st(3'b010, TB + 8, 32'h1);
    repeat (5) tick();
    check("irq_before", {31'b0, oTimer_Irq}, 32'h0);
    tick();
    check("irq_rise", {31'b0, oTimer_Irq}, 32'h1);
    ld("cnt_at_irq", 3'b010, TB, 32'd6);
    st(3'b010, TB + 8, 32'h3);
    check("irq_w1c", {31'b0, oTimer_Irq}, 32'h0);
    ld("cnt_running", 3'b010, TB, 32'd7);
    ld("ctrl_after_w1c", 3'b010, TB + 8, 32'h1);

    st(3'b010, TB, 32'hFFFF_FFFE);
    ld("cnt_load", 3'b010, TB, 32'hFFFF_FFFE);
    tick();
    ld("cnt_max", 3'b010, TB, 32'hFFFF_FFFF);
    tick();
    ld("cnt_wrap", 3'b010, TB, 32'h0);

    st(3'b010, 32'h40, 32'hCAFE_F00D);
    st(3'b010, TB, 32'd5);
    tick();
    check("irq_pre_rst", {31'b0, oTimer_Irq}, 32'h1);
    iRst = 1;
    st(3'b010, 32'h40, 32'h1111_1111);
    iRst = 0;
    check("irq_post_rst", {31'b0, oTimer_Irq}, 32'h0);
    ld("cnt_post_rst", 3'b010, TB, 32'h0);
    ld("ctrl_post_rst", 3'b010, TB + 8, 32'h0);
    ld("ram_post_rst", 3'b010, 32'h40, 32'hCAFE_F00D);

    st(3'b010, 32'h10, 32'hDEAD_BEEF);
    st(3'b000, 32'h12, 32'h0000_007F);
    ld("lw_10", 3'b010, 32'h10, 32'hDE7F_BEEF);
    ld("lb_13", 3'b000, 32'h13, 32'hFFFF_FFDE);
    ld("lbu_13", 3'b100, 32'h13, 32'h0000_00DE);
    ld("lh_10", 3'b001, 32'h10, 32'hFFFF_BEEF);
    ld("lhu_12", 3'b101, 32'h12, 32'h0000_DE7F);
    st(3'b010, 32'h18, 32'h1122_3344);
    st(3'b001, 32'h1A, 32'h0000_ABCD);
    ld("sh_upper", 3'b010, 32'h18, 32'hABCD_3344);
    ld("lh_1a", 3'b001, 32'h1A, 32'hFFFF_ABCD);
    ld("f3_111_as_w", 3'b111, 32'h18, 32'hABCD_3344);

    st(3'b010, 32'h14, 32'hAAAA_5555);
    iFunct3 = 3'b010;
    iData_Addr = 32'h14;
    iData_WrData = 32'h1234_5678;
    iData_WrEn = 1;
    #1;
    check("rdw_old", oData_RdData, 32'hAAAA_5555);
    tick();
    iData_WrEn = 0;
    ld("rdw_new", 3'b010, 32'h14, 32'h1234_5678);

    st(3'b010, 32'h20, 32'h5566_7788);
    iFunct3 = 3'b001;
    iData_Addr = 32'h21;
    iData_WrData = 32'h1234;
    iData_WrEn = 1;
    #1;
    check("sh_mis_flag", {31'b0, oMisalign}, 32'h1);
    tick();
    iData_WrEn = 0;
    ld("sh_mis_nowrite", 3'b010, 32'h20, 32'h5566_7788);
    ld("lw_mis_data", 3'b010, 32'h22, 32'h0);
    check("lw_mis_flag", {31'b0, oMisalign}, 32'h1);
    ld("lb_23", 3'b000, 32'h23, 32'h0000_0055);
    check("lb_mis_flag", {31'b0, oMisalign}, 32'h0);

    st(3'b010, 32'h0, 32'h0BAD_CAFE);
    ld("unmapped_rd", 3'b010, 32'h2000_0000, 32'h0);
    st(3'b010, 32'h2000_0000, 32'hFFFF_FFFF);
    ld("unmapped_wr", 3'b010, 32'h2000_0000, 32'h0);
    ld("no_alias", 3'b010, 32'h0, 32'h0BAD_CAFE);
    st(3'b010, TB + 4, 32'h0000_1234);
    st(3'b000, TB + 4, 32'h0000_0077);
    ld("sb_cmp_ignored", 3'b010, TB + 4, 32'h0000_1234);
    ld("lb_tmr_full", 3'b000, TB + 4, 32'h0000_1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
